btn_event_decoder: RTL and testbench



---
 rtl/btn_evt_pkg.sv | 22 ++
 rtl/btn_edge_det.sv | 23 ++
 rtl/btn_event_decoder.sv | 147 ++++++++++++++
 tb/tb_btn_event_decoder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/btn_evt_pkg.sv
// Shared definitions for the push-button event decoder: FSM state encoding,
// mode-index width and default timing constants for a 50 MHz clock.
package btn_evt_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PRESSED     = 3'd1,
    WAIT_GAP    = 3'd2,
    SECOND_HELD = 3'd3,
    LONG_HELD   = 3'd4
  } state_e;

  localparam int MODE_W = 4;

  // 0.5 s hold, 0.25 s double-press gap, 0.2 s repeat at 50 MHz
  localparam int unsigned DEF_LONG_CNT    = 25000000;
  localparam int unsigned DEF_DBL_GAP_CNT = 12500000;
  localparam int unsigned DEF_REPEAT_CNT  = 10000000;
  localparam int unsigned DEF_NUM_MODES   = 4;
  localparam int unsigned DEF_CNT_W       = 26;

endpackage

// File: rtl/btn_edge_det.sv
// Rise/fall strobe generator for a clk-synchronous level. The history register
// resets to 1 so a button held through reset produces no rise until it has
// been released once.
module btn_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic level_i,
  output logic rise_o,
  output logic fall_o
);

  logic prev_q;

  // Track the level sampled at the previous edge
  always_ff @(posedge clk) begin
    if (!rst_n) prev_q <= 1'b1;
    else        prev_q <= level_i;
  end

  assign rise_o =  level_i & ~prev_q;
  assign fall_o = ~level_i &  prev_q;

endmodule

// File: rtl/btn_event_decoder.sv
// Push-button gesture classifier: short, double and long press pulses, plus the
// grip-mode index and grip-enable flag read by the finger-servo sequencer.
// Optional build macro BTN_REPEAT_EN: long_press re-pulses every REPEAT_CNT
// cycles while the button stays held after a long press.
module btn_event_decoder
  import btn_evt_pkg::*;
#(
  parameter int unsigned LONG_CNT    = DEF_LONG_CNT,
  parameter int unsigned DBL_GAP_CNT = DEF_DBL_GAP_CNT,
  parameter int unsigned REPEAT_CNT  = DEF_REPEAT_CNT,
  parameter int unsigned NUM_MODES   = DEF_NUM_MODES,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pb_level,
  output logic              short_press,
  output logic              double_press,
  output logic              long_press,
  output logic [MODE_W-1:0] mode_sel,
  output logic              grip_en,
  output logic              busy
);

  // The counter is cleared at the entry edge, so at edge Tentry+k it holds k-1;
  // comparing against N-1 therefore fires exactly at edge Tentry+N.
  localparam logic [CNT_W-1:0]  LONG_M1  = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0]  GAP_M1   = CNT_W'(DBL_GAP_CNT - 1);
  localparam logic [MODE_W-1:0] MODE_MAX = MODE_W'(NUM_MODES - 1);

`ifdef BTN_REPEAT_EN
  localparam logic [CNT_W-1:0]  REP_M1   = CNT_W'(REPEAT_CNT - 1);
`else
  // REPEAT_CNT has no function in this build
  logic unused_repeat;
  assign unused_repeat = (REPEAT_CNT != 0);
`endif

  logic              rise, fall;
  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [MODE_W-1:0] mode_q;
  logic              short_q, double_q, long_q, grip_q, busy_q;

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [MODE_W-1:0] mode_inc(input logic [MODE_W-1:0] m);
    return (m == MODE_MAX) ? '0 : m + MODE_W'(1);
  endfunction

  function automatic logic [MODE_W-1:0] mode_dec(input logic [MODE_W-1:0] m);
    return (m == '0) ? MODE_MAX : m - MODE_W'(1);
  endfunction

  btn_edge_det u_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .level_i (pb_level),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  // Gesture FSM with registered event pulses, mode index, grip flag and busy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mode_q   <= '0;
      grip_q   <= 1'b0;
      busy_q   <= 1'b0;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      cnt_q    <= cnt_sat_inc(cnt_q);
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        PRESSED: begin
          // A release on the qualifying edge still counts as a short press
          if (fall) begin
            state_q <= WAIT_GAP;
            cnt_q   <= '0;
          end else if (cnt_q == LONG_M1) begin
            long_q  <= 1'b1;
            grip_q  <= ~grip_q;
            state_q <= LONG_HELD;
            cnt_q   <= '0;
          end
        end
        WAIT_GAP: begin
          // A second press on the last gap edge still counts as a double press
          if (rise) begin
            double_q <= 1'b1;
            mode_q   <= mode_dec(mode_q);
            state_q  <= SECOND_HELD;
          end else if (cnt_q == GAP_M1) begin
            short_q <= 1'b1;
            mode_q  <= mode_inc(mode_q);
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        SECOND_HELD: begin
          if (fall) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        LONG_HELD: begin
          if (fall) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
`ifdef BTN_REPEAT_EN
          else if (cnt_q == REP_M1) begin
            long_q <= 1'b1;
            cnt_q  <= '0;
          end
`endif
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign short_press  = short_q;
  assign double_press = double_q;
  assign long_press   = long_q;
  assign mode_sel     = mode_q;
  assign grip_en      = grip_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_btn_event_decoder.sv
// Directed, table-driven bench for btn_event_decoder with short timing constants.
module tb_btn_event_decoder;

  localparam int LONG_CNT    = 8;
  localparam int DBL_GAP_CNT = 5;
  localparam int REPEAT_CNT  = 4;
  localparam int NUM_MODES   = 4;
  localparam int CNT_W       = 8;

`ifdef BTN_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pb_level;
  logic       short_press, double_press, long_press, grip_en, busy;
  logic [3:0] mode_sel;

  always #5 clk = ~clk;

  btn_event_decoder #(
    .LONG_CNT    (LONG_CNT),
    .DBL_GAP_CNT (DBL_GAP_CNT),
    .REPEAT_CNT  (REPEAT_CNT),
    .NUM_MODES   (NUM_MODES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pb_level     (pb_level),
    .short_press  (short_press),
    .double_press (double_press),
    .long_press   (long_press),
    .mode_sel     (mode_sel),
    .grip_en      (grip_en),
    .busy         (busy)
  );

  // expected output bundle: {short, double, long, mode[3:0], grip, busy}
  typedef struct {
    logic       r;
    logic       p;
    logic [8:0] e;
  } vec_t;

  vec_t vq[$];
  int   tests = 0;
  int   fails = 0;
  int   s_cnt, d_cnt, l_cnt, multi_cnt;

  function automatic logic [8:0] pk(bit s, bit d, bit l, int m, bit g, bit b);
    return {s, d, l, 4'(m), g, b};
  endfunction

  function automatic logic [8:0] zq(int m, bit g);   // idle, no pulse
    return pk(0, 0, 0, m, g, 0);
  endfunction

  function automatic logic [8:0] bz(int m, bit g);   // busy, no pulse
    return pk(0, 0, 0, m, g, 1);
  endfunction

  task automatic add(int n, bit r, bit p, logic [8:0] e);
    repeat (n) vq.push_back('{r, p, e});
  endtask

  // 3-cycle press, release, gap expires at Tf+5
  task automatic add_short(int mo, int mn, bit g);
    add(3, 1, 1, bz(mo, g));
    add(5, 1, 0, bz(mo, g));
    add(1, 1, 0, pk(1, 0, 0, mn, g, 0));
    add(2, 1, 0, zq(mn, g));
  endtask

  task automatic step(bit r, bit p);
    @(negedge clk);
    rst_n    = r;
    pb_level = p;
    @(posedge clk);
    #1;
    s_cnt += int'(short_press);
    d_cnt += int'(double_press);
    l_cnt += int'(long_press);
    if (int'(short_press) + int'(double_press) + int'(long_press) > 1) multi_cnt++;
  endtask

  task automatic chk(string name, int got, int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic clr_counts();
    s_cnt = 0; d_cnt = 0; l_cnt = 0; multi_cnt = 0;
  endtask

  initial begin
    logic [8:0] got;
    rst_n    = 1'b0;
    pb_level = 1'b0;

    // reset state, then plain short press 0 -> 1
    add(2, 0, 0, zq(0, 0));
    add(2, 1, 0, zq(0, 0));
    add_short(0, 1, 0);
    // reset clears mode
    add(2, 0, 0, zq(0, 0));
    add(1, 1, 0, zq(0, 0));
    // double press: press 3, release 2, press 3, release; mode 0 -> 3
    add(3, 1, 1, bz(0, 0));
    add(2, 1, 0, bz(0, 0));
    add(1, 1, 1, pk(0, 1, 0, 3, 0, 1));
    add(2, 1, 1, bz(3, 0));
    add(4, 1, 0, zq(3, 0));
    // four short presses from 0: 1, 2, 3, 0
    add(2, 0, 0, zq(0, 0));
    add(1, 1, 0, zq(0, 0));
    add_short(0, 1, 0);
    add_short(1, 2, 0);
    add_short(2, 3, 0);
    add_short(3, 0, 0);
    // long hold of 20 cycles: long at T0+8, repeats at T0+12/T0+16 if built
    add(8, 1, 1, bz(0, 0));
    add(1, 1, 1, pk(0, 0, 1, 0, 1, 1));
    for (int k = 9; k <= 19; k++)
      add(1, 1, 1, pk(0, 0, REP && (k == 12 || k == 16), 0, 1, 1));
    add(7, 1, 0, zq(0, 1));
    // fall exactly at T0+8: no long press, short at Tf+5
    add(8, 1, 1, bz(0, 1));
    add(5, 1, 0, bz(0, 1));
    add(1, 1, 0, pk(1, 0, 0, 1, 1, 0));
    add(2, 1, 0, zq(1, 1));
    // rise exactly at Tf+5: double wins over short
    add(3, 1, 1, bz(1, 1));
    add(5, 1, 0, bz(1, 1));
    add(1, 1, 1, pk(0, 1, 0, 0, 1, 1));
    add(2, 1, 1, bz(0, 1));
    add(9, 1, 0, zq(0, 1));
    // held through reset release: ignored until released, then normal short
    add(2, 0, 1, zq(0, 0));
    add(30, 1, 1, zq(0, 0));
    add(2, 1, 0, zq(0, 0));
    add_short(0, 1, 0);
    // reset during WAIT_GAP abandons the gesture
    add(3, 1, 1, bz(1, 0));
    add(2, 1, 0, bz(1, 0));
    add(2, 0, 0, zq(0, 0));
    add(8, 1, 0, zq(0, 0));

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst_n    = vq[i].r;
      pb_level = vq[i].p;
      @(posedge clk);
      #1;
      got = {short_press, double_press, long_press, mode_sel, grip_en, busy};
      tests++;
      if (got !== vq[i].e) begin
        fails++;
        $display("FAIL vec[%0d] {s,d,l,mode,grip,busy}: got %b, expected %b",
                 i, got, vq[i].e);
      end
    end

    // double press then hold long: no long-press detection in SECOND_HELD
    clr_counts();
    repeat (2) step(1, 1);
    repeat (2) step(1, 0);
    repeat (20) step(1, 1);
    repeat (8) step(1, 0);
    chk("dbl_hold_double_cnt", d_cnt, 1);
    chk("dbl_hold_long_cnt", l_cnt, 0);
    chk("dbl_hold_short_cnt", s_cnt, 0);
    chk("dbl_hold_mode", int'(mode_sel), 3);
    chk("dbl_hold_busy", int'(busy), 0);

    // two long presses toggle grip_en on then off
    clr_counts();
    repeat (10) step(1, 1);
    repeat (3) step(1, 0);
    chk("grip_after_long1", int'(grip_en), 1);
    repeat (10) step(1, 1);
    repeat (8) step(1, 0);
    chk("grip_after_long2", int'(grip_en), 0);
    chk("long2_long_cnt", l_cnt, 2);
    chk("long2_short_cnt", s_cnt, 0);
    chk("long2_mode", int'(mode_sel), 3);

    // long idle past counter saturation, then short press wraps 3 -> 0
    clr_counts();
    repeat (300) step(1, 0);
    repeat (3) step(1, 1);
    repeat (10) step(1, 0);
    chk("sat_short_cnt", s_cnt, 1);
    chk("sat_mode_wrap", int'(mode_sel), 0);
    chk("sat_multi_pulse", multi_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
